// File: rtl/schiebe_steuerwerk.sv
// rtl/schiebe_steuerwerk.sv - two-stage shift/rotate sequencer around an external barrel rotator
// Optional carry/zero flags: SCHIEBER_FLAGS_EN
module schiebe_steuerwerk #(
    parameter int BREITE     = 32,
    parameter int LOG2BREITE = 5
) (
    input  logic                  Takt,
    input  logic                  nReset,
    input  logic                  EingabeGueltig,
    output logic                  EingabeBereit,
    input  logic [2:0]            Operation,
    input  logic [BREITE-1:0]     Zahl,
    input  logic [LOG2BREITE-1:0] Stellen,
    output logic [BREITE-1:0]     RotZahl,
    output logic [LOG2BREITE-1:0] RotStellen,
    output logic                  RotRechts,
    input  logic [BREITE-1:0]     RotErgebnis,
    output logic [BREITE-1:0]     Ergebnis,
    output logic                  Uebertrag,
    output logic                  Null,
    output logic                  Fehler,
    output logic                  AusgabeGueltig,
    input  logic                  AusgabeBereit
);

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    localparam logic [BREITE-1:0] ALLE_EINS = {BREITE{1'b1}};

    // Stage 1 registers
    logic                  s1_valid_q, s1_valid_d;
    logic [BREITE-1:0]     s1_zahl_q, s1_zahl_d;
    logic [LOG2BREITE-1:0] s1_stellen_q, s1_stellen_d;
    logic [2:0]            s1_op_q, s1_op_d;

    // Stage 2 registers
    logic                  s2_valid_q, s2_valid_d;
    logic [BREITE-1:0]     s2_ergebnis_q, s2_ergebnis_d;
    logic                  s2_fehler_q, s2_fehler_d;

    logic                  advance1;
    logic                  in_fire;
    logic [BREITE-1:0]     maske;
    logic [BREITE-1:0]     ergebnis_c;
    logic                  fehler_c;

    always_comb begin
        advance1      = !s2_valid_q || AusgabeBereit;
        EingabeBereit = !s1_valid_q || advance1;
        in_fire       = EingabeGueltig && EingabeBereit;
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_zahl_d    = s1_zahl_q;
        s1_stellen_d = s1_stellen_q;
        s1_op_d      = s1_op_q;
        if (in_fire) begin
            s1_valid_d   = 1'b1;
            s1_zahl_d    = Zahl;
            s1_stellen_d = Stellen;
            s1_op_d      = Operation;
        end else if (advance1) begin
            s1_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge Takt or negedge nReset) begin
        if (!nReset) begin
            s1_valid_q   <= 1'b0;
            s1_zahl_q    <= '0;
            s1_stellen_q <= '0;
            s1_op_q      <= OP_SLL;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_zahl_q    <= s1_zahl_d;
            s1_stellen_q <= s1_stellen_d;
            s1_op_q      <= s1_op_d;
        end
    end

    always_comb begin
        RotZahl    = s1_zahl_q;
        RotStellen = s1_stellen_q;
        RotRechts  = (s1_op_q == OP_SRL) || (s1_op_q == OP_SRA) || (s1_op_q == OP_ROR);
    end

    // Shifts are rotations with the wrapped-around bits masked off (or sign-filled for SRA)
    always_comb begin
        maske      = ALLE_EINS;
        ergebnis_c = '0;
        fehler_c   = 1'b0;
        case (s1_op_q)
            OP_SLL: begin
                maske      = ALLE_EINS << s1_stellen_q;
                ergebnis_c = RotErgebnis & maske;
            end
            OP_SRL: begin
                maske      = ALLE_EINS >> s1_stellen_q;
                ergebnis_c = RotErgebnis & maske;
            end
            OP_SRA: begin
                maske      = ALLE_EINS >> s1_stellen_q;
                ergebnis_c = (RotErgebnis & maske) | (s1_zahl_q[BREITE-1] ? ~maske : '0);
            end
            OP_ROL, OP_ROR: begin
                ergebnis_c = RotErgebnis;
            end
            default: begin
                fehler_c   = 1'b1;
            end
        endcase
    end

    always_comb begin
        s2_valid_d    = s2_valid_q;
        s2_ergebnis_d = s2_ergebnis_q;
        s2_fehler_d   = s2_fehler_q;
        if (advance1) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_ergebnis_d = ergebnis_c;
                s2_fehler_d   = fehler_c;
            end
        end
    end

    always_ff @(posedge Takt or negedge nReset) begin
        if (!nReset) begin
            s2_valid_q    <= 1'b0;
            s2_ergebnis_q <= '0;
            s2_fehler_q   <= 1'b0;
        end else begin
            s2_valid_q    <= s2_valid_d;
            s2_ergebnis_q <= s2_ergebnis_d;
            s2_fehler_q   <= s2_fehler_d;
        end
    end

    always_comb begin
        AusgabeGueltig = s2_valid_q;
        Ergebnis       = s2_ergebnis_q;
        Fehler         = s2_fehler_q;
    end

`ifdef SCHIEBER_FLAGS_EN
    localparam logic [LOG2BREITE-1:0] STELLEN_NULL = '0;
    localparam logic [LOG2BREITE-1:0] STELLEN_EINS = {{(LOG2BREITE-1){1'b0}}, 1'b1};

    logic                  s2_uebertrag_q, s2_uebertrag_d;
    logic                  s2_null_q, s2_null_d;
    logic                  uebertrag_c;
    logic [LOG2BREITE-1:0] idx_links;
    logic [LOG2BREITE-1:0] idx_rechts;

    // BREITE is a power of two, so BREITE-Stellen wraps to 0 - Stellen
    always_comb begin
        idx_links   = STELLEN_NULL - s1_stellen_q;
        idx_rechts  = s1_stellen_q - STELLEN_EINS;
        uebertrag_c = 1'b0;
        if (s1_stellen_q != STELLEN_NULL) begin
            case (s1_op_q)
                OP_SLL:         uebertrag_c = s1_zahl_q[idx_links];
                OP_SRL, OP_SRA: uebertrag_c = s1_zahl_q[idx_rechts];
                OP_ROL:         uebertrag_c = ergebnis_c[0];
                OP_ROR:         uebertrag_c = ergebnis_c[BREITE-1];
                default:        uebertrag_c = 1'b0;
            endcase
        end
    end

    always_comb begin
        s2_uebertrag_d = s2_uebertrag_q;
        s2_null_d      = s2_null_q;
        if (advance1 && s1_valid_q) begin
            s2_uebertrag_d = uebertrag_c;
            s2_null_d      = (ergebnis_c == '0);
        end
    end

    always_ff @(posedge Takt or negedge nReset) begin
        if (!nReset) begin
            s2_uebertrag_q <= 1'b0;
            s2_null_q      <= 1'b0;
        end else begin
            s2_uebertrag_q <= s2_uebertrag_d;
            s2_null_q      <= s2_null_d;
        end
    end

    always_comb begin
        Uebertrag = s2_uebertrag_q;
        Null      = s2_null_q;
    end
`else
    always_comb begin
        Uebertrag = 1'b0;
        Null      = 1'b0;
    end
`endif

endmodule
